display_hub75_driver: RTL and testbench

DISPLAY_HUB75_DRIVER -- requirements
Module: display_hub75_driver

---
 rtl/display_hub75_driver_pkg.sv | 14 +
 rtl/display_hub75_driver.sv | 176 +++++++++++++++++
 tb/tb_display_hub75_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/display_hub75_driver_pkg.sv
// Shared FSM encoding and small helpers for the HUB75 panel driver.
package display_hub75_driver_pkg;
    typedef logic [1:0] state_t;

    localparam state_t st_idle  = 2'd0;
    localparam state_t st_shift = 2'd1;
    localparam state_t st_latch = 2'd2;
    localparam state_t st_blank = 2'd3;

    // True when a phase count sits an even distance above offset.
    function automatic logic phase_aligned(input logic phase_lsb, input int offset);
        return phase_lsb == offset[0];
    endfunction
endpackage

// File: rtl/display_hub75_driver.sv
// HUB75 panel scan driver: shifts one row pass per modulation cycle, latches,
// and blanks the panel while the row address settles.
module display_hub75_driver
    import display_hub75_driver_pkg::*;
#(
    parameter int segments     = 2,
    parameter int columns      = 64,
    parameter int rows         = 16,
    parameter int cycle_bits   = 8,
    parameter int latency      = 2,
    parameter int blank_clocks = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [$clog2(columns)-1:0] column,
    output logic [$clog2(rows)-1:0]    row,
    output logic [cycle_bits-1:0]      cycle,
    input  logic [3*segments-1:0]      rgb,
    output logic [3*segments-1:0]      panel_rgb,
    output logic                       panel_clk,
    output logic                       panel_latch,
    output logic                       panel_oe,
    output logic [$clog2(rows)-1:0]    panel_addr,
    output logic                       frame
);
    localparam int col_w     = $clog2(columns);
    localparam int row_w     = $clog2(rows);
    localparam int rgb_w     = 3 * segments;
    localparam int shift_len = 2 * columns + latency + 1;
    localparam int phase_max = (shift_len > blank_clocks) ? shift_len : blank_clocks;
    localparam int phase_w   = $clog2(phase_max + 1);

    state_t             state_r, state_s;
    logic [phase_w-1:0] phase_r, phase_s;
    logic               first_pass_r, first_pass_s;
    logic [col_w-1:0]   column_r, col_s;
    logic [row_w-1:0]   row_r, row_inc_s, addr_r;
    logic [cycle_bits-1:0] cycle_r;
    logic [rgb_w-1:0]   rgb_r;
    logic               clk_r, latch_r, oe_r, frame_r;
    logic               cycle_wrap_s, pulse_s, load_s;

    // Next state and the shared SHIFT/BLANK phase counter.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        case (state_r)
            st_idle: begin
                if (enable) begin
                    state_s = st_shift;
                    phase_s = {phase_w{1'b0}};
                end else begin
                    state_s = st_idle;
                    phase_s = {phase_w{1'b0}};
                end
            end
            st_shift: begin
                if (phase_r == phase_w'(shift_len - 1)) begin
                    state_s = st_latch;
                    phase_s = {phase_w{1'b0}};
                end else begin
                    phase_s = phase_r + phase_w'(1);
                end
            end
            st_latch: begin
                phase_s = {phase_w{1'b0}};
                if (!enable) begin
                    state_s = st_idle;
                end else if ((blank_clocks != 0) && (row_inc_s != addr_r)) begin
                    state_s = st_blank;
                end else begin
                    state_s = st_shift;
                end
            end
            st_blank: begin
                if (phase_r == phase_w'(blank_clocks - 1)) begin
                    state_s = st_shift;
                    phase_s = {phase_w{1'b0}};
                end else begin
                    phase_s = phase_r + phase_w'(1);
                end
            end
            default: begin
                state_s = st_idle;
                phase_s = {phase_w{1'b0}};
            end
        endcase
    end

    // Row advance on cycle wrap, first-pass tracking and column decode.
    always_comb begin
        cycle_wrap_s = &cycle_r;
        row_inc_s    = row_r;
        if (cycle_wrap_s) begin
            if (row_r == row_w'(rows - 1)) begin
                row_inc_s = {row_w{1'b0}};
            end else begin
                row_inc_s = row_r + row_w'(1);
            end
        end else begin
            row_inc_s = row_r;
        end

        first_pass_s = first_pass_r;
        if (state_r == st_idle) begin
            first_pass_s = 1'b1;
        end else if (state_r == st_latch) begin
            first_pass_s = 1'b0;
        end else begin
            first_pass_s = first_pass_r;
        end

        col_s = column_r;
        if (phase_s >= phase_w'(2 * columns - 2)) begin
            col_s = col_w'(columns - 1);
        end else begin
            col_s = col_w'(phase_s >> 1);
        end
    end

    // Pixel data lands latency clocks after its column; the shift clock follows one clock later.
    assign load_s  = (state_r == st_shift) && (phase_r >= phase_w'(latency)) &&
                     (phase_r <= phase_w'(2 * columns + latency - 2)) &&
                     phase_aligned(phase_r[0], latency);
    assign pulse_s = (state_s == st_shift) && (phase_s >= phase_w'(latency + 1)) &&
                     (phase_s <= phase_w'(2 * columns + latency - 1)) &&
                     phase_aligned(phase_s[0], latency + 1);

    // State, counters and all registered panel/framebuffer outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= st_idle;
            phase_r      <= {phase_w{1'b0}};
            first_pass_r <= 1'b1;
            column_r     <= {col_w{1'b0}};
            row_r        <= {row_w{1'b0}};
            cycle_r      <= {cycle_bits{1'b0}};
            addr_r       <= {row_w{1'b0}};
            rgb_r        <= {rgb_w{1'b0}};
            clk_r        <= 1'b0;
            latch_r      <= 1'b0;
            oe_r         <= 1'b1;
            frame_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            first_pass_r <= first_pass_s;
            if (state_s == st_shift) begin
                column_r <= col_s;
            end
            if (load_s) begin
                rgb_r <= rgb;
            end
            if (state_r == st_latch) begin
                cycle_r <= cycle_r + cycle_bits'(1);
                row_r   <= row_inc_s;
                addr_r  <= row_inc_s;
            end
            clk_r   <= pulse_s;
            latch_r <= (state_s == st_latch);
            oe_r    <= (state_s == st_shift) ? first_pass_s : 1'b1;
            frame_r <= (state_s == st_latch) && cycle_wrap_s && (row_r == row_w'(rows - 1));
        end
    end

    assign column      = column_r;
    assign row         = row_r;
    assign cycle       = cycle_r;
    assign panel_rgb   = rgb_r;
    assign panel_clk   = clk_r;
    assign panel_latch = latch_r;
    assign panel_oe    = oe_r;
    assign panel_addr  = addr_r;
    assign frame       = frame_r;
endmodule

// File: tb/tb_display_hub75_driver.sv
// Randomized bench for display_hub75_driver against a pass-level reference model.
module tb_display_hub75_driver;
    localparam int segments     = 2;
    localparam int columns      = 4;
    localparam int rows         = 2;
    localparam int cycle_bits   = 2;
    localparam int latency      = 2;
    localparam int blank_clocks = 2;
    localparam int shift_len    = 2 * columns + latency + 1;
    localparam int n_cycles     = 1 << cycle_bits;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [5:0] rgb = 6'd0;
    logic [1:0] column;
    logic [0:0] row;
    logic [1:0] cycle;
    logic [5:0] panel_rgb;
    logic panel_clk, panel_latch, panel_oe;
    logic [0:0] panel_addr;
    logic frame;

    display_hub75_driver #(
        .segments(segments), .columns(columns), .rows(rows),
        .cycle_bits(cycle_bits), .latency(latency), .blank_clocks(blank_clocks)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .column(column), .row(row),
        .cycle(cycle), .rgb(rgb), .panel_rgb(panel_rgb), .panel_clk(panel_clk),
        .panel_latch(panel_latch), .panel_oe(panel_oe), .panel_addr(panel_addr),
        .frame(frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] tbl [columns];
    int col_hist [$];
    int m_row = 0, m_cycle = 0, m_addr = 0;
    int frames_seen = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to mid-clock; framebuffer model returns the pixel of the column seen latency clocks ago.
    task automatic step();
        @(negedge clk);
        col_hist.push_back(int'(column));
        if (col_hist.size() > 8) void'(col_hist.pop_front());
        if (col_hist.size() > latency) rgb = tbl[col_hist[col_hist.size() - 1 - latency]];
        else rgb = 6'd0;
    endtask

    task automatic check_reset_values();
        check_value("rst_column", 32'(column), 32'd0);
        check_value("rst_row", 32'(row), 32'd0);
        check_value("rst_cycle", 32'(cycle), 32'd0);
        check_value("rst_addr", 32'(panel_addr), 32'd0);
        check_value("rst_rgb", 32'(panel_rgb), 32'd0);
        check_value("rst_clk", 32'(panel_clk), 32'd0);
        check_value("rst_latch", 32'(panel_latch), 32'd0);
        check_value("rst_oe", 32'(panel_oe), 32'd1);
        check_value("rst_frame", 32'(frame), 32'd0);
    endtask

    // One row pass: SHIFT, LATCH, then IDLE or BLANK as the model predicts.
    task automatic run_pass(input bit first, input int drop_at, input int rst_at);
        int pulses;
        int c_exp;
        bit is_pulse;
        bit changed;
        pulses = 0;
        for (int c = 0; c < columns; c++) tbl[c] = 6'($urandom);
        for (int k = 0; k < shift_len; k++) begin
            step();
            c_exp = (k / 2 < columns) ? k / 2 : columns - 1;
            is_pulse = (k >= latency + 1) && ((k - latency - 1) % 2 == 0) &&
                       ((k - latency - 1) / 2 < columns);
            check_value("column", 32'(column), 32'(c_exp));
            check_value("panel_clk", 32'(panel_clk), 32'(is_pulse));
            if (is_pulse) check_value("panel_rgb", 32'(panel_rgb), 32'(tbl[(k - latency - 1) / 2]));
            pulses += int'(panel_clk);
            check_value("shift_oe", 32'(panel_oe), 32'(first));
            check_value("shift_latch", 32'(panel_latch), 32'd0);
            check_value("shift_row", 32'(row), 32'(m_row));
            check_value("shift_cycle", 32'(cycle), 32'(m_cycle));
            check_value("shift_addr", 32'(panel_addr), 32'(m_addr));
            check_value("shift_frame", 32'(frame), 32'd0);
            if (k == drop_at) enable = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                check_reset_values();
                return;
            end
        end
        check_value("pulse_count", 32'(pulses), 32'(columns));
        step();
        check_value("latch", 32'(panel_latch), 32'd1);
        check_value("latch_oe", 32'(panel_oe), 32'd1);
        check_value("latch_clk", 32'(panel_clk), 32'd0);
        check_value("latch_frame", 32'(frame),
                    32'((m_cycle == n_cycles - 1) && (m_row == rows - 1)));
        frames_seen += int'(frame);
        m_cycle = (m_cycle + 1) % n_cycles;
        if (m_cycle == 0) m_row = (m_row + 1) % rows;
        changed = (m_row != m_addr);
        m_addr = m_row;
        if (!enable) begin
            step();
            check_value("idle_oe", 32'(panel_oe), 32'd1);
            check_value("idle_clk", 32'(panel_clk), 32'd0);
            check_value("idle_latch", 32'(panel_latch), 32'd0);
            check_value("idle_row", 32'(row), 32'(m_row));
            check_value("idle_cycle", 32'(cycle), 32'(m_cycle));
            check_value("idle_addr", 32'(panel_addr), 32'(m_addr));
        end else if (changed) begin
            for (int b = 0; b < blank_clocks; b++) begin
                step();
                check_value("blank_oe", 32'(panel_oe), 32'd1);
                check_value("blank_clk", 32'(panel_clk), 32'd0);
                check_value("blank_latch", 32'(panel_latch), 32'd0);
                check_value("blank_addr", 32'(panel_addr), 32'(m_addr));
                check_value("blank_row", 32'(row), 32'(m_row));
            end
        end
    endtask

    initial begin
        int drop;
        int waits;
        bit first_flag;
        for (int c = 0; c < columns; c++) tbl[c] = 6'd0;
        repeat (3) step();
        check_reset_values();
        rst = 1'b0;
        step();
        check_value("idle_hold_oe", 32'(panel_oe), 32'd1);
        check_value("idle_hold_clk", 32'(panel_clk), 32'd0);
        enable = 1'b1;
        run_pass(1'b1, -1, -1);
        for (int p = 1; p < rows * n_cycles; p++) run_pass(1'b0, -1, -1);
        check_value("frame_count", 32'(frames_seen), 32'd1);
        check_value("wrap_row", 32'(row), 32'd0);
        check_value("wrap_cycle", 32'(cycle), 32'd0);

        first_flag = 1'b0;
        for (int p = 0; p < 16; p++) begin
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, shift_len - 1)) : -1;
            run_pass(first_flag, drop, -1);
            first_flag = 1'b0;
            if (!enable) begin
                waits = int'($urandom_range(0, 3));
                for (int w = 0; w < waits; w++) begin
                    step();
                    check_value("idle_wait_oe", 32'(panel_oe), 32'd1);
                    check_value("idle_wait_latch", 32'(panel_latch), 32'd0);
                end
                enable = 1'b1;
                first_flag = 1'b1;
            end
        end

        run_pass(first_flag, -1, int'($urandom_range(1, shift_len - 2)));
        step();
        check_value("rst_hold_latch", 32'(panel_latch), 32'd0);
        check_value("rst_hold_oe", 32'(panel_oe), 32'd1);
        rst = 1'b0;
        m_row = 0;
        m_cycle = 0;
        m_addr = 0;
        run_pass(1'b1, -1, -1);
        run_pass(1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000");
        $fatal(1, "bench timeout");
    end
endmodule
